// File: rtl/updown_sweep_ctrl.sv
// updown_sweep_ctrl: drives an external up/down counter back and forth between latched bounds.
// Ports: clk/rst (async active-low); cmd_valid/cmd_ready/cmd_lo/cmd_hi/cmd_sweeps accept a sweep;
// stop aborts it; cnt_in is the counter value; load/data/Up_Down steer the counter;
// busy marks a running sweep; done/err are one-cycle registered completion/error pulses.
module updown_sweep_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_lo,
  input  logic [WIDTH-1:0] cmd_hi,
  input  logic [3:0]       cmd_sweeps,
  input  logic             stop,
  input  logic [WIDTH-1:0] cnt_in,
  output logic             load,
  output logic [WIDTH-1:0] data,
  output logic             Up_Down,
  output logic             busy,
  output logic             done,
  output logic             err
);
  typedef enum logic [1:0] {IDLE, LOAD, UP, DOWN} state_t;
  state_t state, state_nx;
  logic [WIDTH-1:0] lo, hi, lo_nx, hi_nx;
  logic [3:0] n, hc, n_nx, hc_nx, hc_inc;
  logic done_nx, err_nx, last;
  assign hc_inc = hc + 4'd1;
  // reaching an endpoint now finishes the sweep; n == 0 never finishes
  assign last = (n != 4'd0) && (hc_inc == n);
  assign busy = state != IDLE;
  assign cmd_ready = state == IDLE;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      lo <= '0;
      hi <= '0;
      n <= '0;
      hc <= '0;
      done <= 1'b0;
      err <= 1'b0;
    end else begin
      state <= state_nx;
      lo <= lo_nx;
      hi <= hi_nx;
      n <= n_nx;
      hc <= hc_nx;
      done <= done_nx;
      err <= err_nx;
    end
  end
  always_comb begin
    state_nx = state;
    lo_nx = lo;
    hi_nx = hi;
    n_nx = n;
    hc_nx = hc;
    done_nx = 1'b0;
    err_nx = 1'b0;
    case (state)
      IDLE: if (cmd_valid) begin
        lo_nx = cmd_lo;
        hi_nx = cmd_hi;
        n_nx = cmd_sweeps;
        hc_nx = 4'd0;
        err_nx = cmd_lo >= cmd_hi;
        state_nx = cmd_lo >= cmd_hi ? IDLE : LOAD;
      end
      LOAD: state_nx = stop ? IDLE : UP;
      UP: if (stop) state_nx = IDLE;
        else if (cnt_in > hi) begin
          state_nx = IDLE;
          err_nx = 1'b1;
        end else if (cnt_in == hi) begin
          hc_nx = hc_inc;
          done_nx = last;
          state_nx = last ? IDLE : DOWN;
        end
      DOWN: if (stop) state_nx = IDLE;
        else if (cnt_in < lo) begin
          state_nx = IDLE;
          err_nx = 1'b1;
        end else if (cnt_in == lo) begin
          hc_nx = hc_inc;
          done_nx = last;
          state_nx = last ? IDLE : UP;
        end
      default: state_nx = IDLE;
    endcase
  end
  // default freezes the counter by reloading its own value; only in-range,
  // non-final running cycles release it to count
  always_comb begin
    load = 1'b1;
    data = cnt_in;
    Up_Down = 1'b1;
    case (state)
      LOAD: data = stop ? cnt_in : lo;
      UP: if (!stop && cnt_in <= hi && !(cnt_in == hi && last)) begin
        load = 1'b0;
        Up_Down = cnt_in != hi;
      end
      DOWN: if (!stop && cnt_in >= lo && !(cnt_in == lo && last)) begin
        load = 1'b0;
        Up_Down = cnt_in == lo;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_updown_sweep_ctrl.sv
// tb_updown_sweep_ctrl: randomized sweeps checked against an arithmetic bounce model.
module tb_updown_sweep_ctrl;
  localparam int W = 4;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic cmd_valid = 1'b0;
  logic stop = 1'b0;
  logic frc = 1'b0;
  logic [W-1:0] cmd_lo = '0, cmd_hi = '0, fval = '0;
  logic [W-1:0] cnt = 4'd9;
  logic [3:0] cmd_sweeps = '0;
  logic [W-1:0] cnt_in, data;
  logic cmd_ready, load, Up_Down, busy, done, err;
  int ncmp = 0;
  int nerr = 0;

  updown_sweep_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_lo(cmd_lo), .cmd_hi(cmd_hi), .cmd_sweeps(cmd_sweeps), .stop(stop),
    .cnt_in(cnt_in), .load(load), .data(data), .Up_Down(Up_Down),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;
  assign cnt_in = frc ? fval : cnt;
  always @(posedge clk) cnt <= load ? data : (Up_Down ? cnt + 1'b1 : cnt - 1'b1);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    ncmp++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // counter value k cycles after the load: a triangle wave of period 2L
  function automatic int model_val(int lo, int l, int k);
    int p = k % (2 * l);
    return p <= l ? lo + p : lo + 2 * l - p;
  endfunction

  function automatic bit model_dir(int l, int k);
    return (k % (2 * l)) < l;
  endfunction

  task automatic accept(int lo, int hi, int n, bit hold);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_lo = W'(lo);
    cmd_hi = W'(hi);
    cmd_sweeps = 4'(n);
    #1 chk("accept_ready", {busy, cmd_ready}, 2'b01);
    @(negedge clk);
    cmd_valid = hold;
    cmd_lo = W'($urandom);
    cmd_hi = W'($urandom);
    cmd_sweeps = 4'($urandom);
    #1 chk("load_state", {busy, load, cmd_ready, Up_Down}, 4'b1101);
    chk("load_data", data, lo);
  endtask

  task automatic run_sweep(int lo, int hi, int n, int stop_at, bit hold);
    int l = hi - lo;
    int last_k = n == 0 ? -1 : n * l;
    int k = 0;
    bit fin = 0;
    bit ended = 0;
    accept(lo, hi, n, hold);
    while (!ended && k < 300) begin
      @(negedge clk);
      stop = k == stop_at;
      #1 chk("run_cnt", cnt_in, model_val(lo, l, k));
      chk("run_flags", {busy, done, err, cmd_ready}, 4'b1000);
      fin = !stop && k == last_k;
      ended = stop || fin;
      if (ended) begin
        cmd_valid = 1'b0;
        chk("end_load", {load, data}, {1'b1, W'(model_val(lo, l, k))});
      end else begin
        chk("run_ctl", {load, Up_Down}, {1'b0, model_dir(l, k)});
        k++;
      end
    end
    if (!ended) chk("sweep_timeout", 0, 1);
    @(negedge clk);
    stop = 1'b0;
    cmd_valid = 1'b0;
    #1 chk("end_flags", {busy, done, err, cmd_ready}, {1'b0, fin, 2'b01});
    chk("end_hold", cnt_in, model_val(lo, l, k));
    @(negedge clk);
    #1 chk("after_end", {done, err, load, busy}, 4'b0010);
    chk("frozen", cnt_in, model_val(lo, l, k));
  endtask

  task automatic bad_cmd(int lo, int hi);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_lo = W'(lo);
    cmd_hi = W'(hi);
    cmd_sweeps = 4'($urandom);
    #1 chk("bad_ready", cmd_ready, 1);
    @(negedge clk);
    cmd_valid = 1'b0;
    #1 chk("bad_err", {err, done, busy, load}, 4'b1001);
    chk("bad_data", data, cnt_in);
    @(negedge clk);
    #1 chk("bad_err_clr", {err, busy, load}, 3'b001);
  endtask

  task automatic oor_case(int lo, int hi, int fk, int fv);
    accept(lo, hi, 0, 1'b0);
    for (int k = 0; k < fk; k++) begin
      @(negedge clk);
      #1 chk("oor_pre_cnt", cnt_in, model_val(lo, hi - lo, k));
    end
    @(negedge clk);
    frc = 1'b1;
    fval = W'(fv);
    #1 chk("oor_out", {load, data, busy}, {1'b1, W'(fv), 1'b1});
    @(negedge clk);
    #1 chk("oor_err", {err, done, busy, load}, 4'b1001);
    chk("oor_data", data, fv);
    @(negedge clk);
    frc = 1'b0;
    #1 chk("oor_clr", {err, busy, cnt_in}, {2'b00, W'(fv)});
  endtask

  initial begin
    #2 chk("rst_flags", {busy, done, err, cmd_ready, load, Up_Down}, 6'b000111);
    chk("rst_data", data, 9);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1 chk("post_rst", {busy, cmd_ready, cnt_in}, {2'b01, 4'd9});
    run_sweep(2, 5, 2, -1, 1'b0);
    bad_cmd(5, 5);
    bad_cmd(9, 3);
    run_sweep(0, 15, 0, 40, 1'b0);
    run_sweep(3, 7, 1, -1, 1'b1);
    oor_case(1, 4, 1, 7);
    oor_case(3, 6, 4, 1);
    accept(2, 9, 3, 1'b0);
    for (int k = 0; k <= 10; k++) begin
      @(negedge clk);
      #1 chk("pre_rst_cnt", cnt_in, model_val(2, 7, k));
    end
    @(negedge clk);
    rst = 1'b0;
    #1 chk("mid_rst", {busy, done, err, cmd_ready, load, Up_Down}, 6'b000111);
    chk("mid_rst_data", data, cnt_in);
    @(negedge clk);
    #1 chk("mid_rst_hold", {busy, done, err, cmd_ready}, 4'b0001);
    rst = 1'b1;
    @(negedge clk);
    #1 chk("rel_rst", {busy, done, err, cmd_ready}, 4'b0001);
    run_sweep(4, 8, 1, -1, 1'b0);
    for (int i = 0; i < 25; i++) begin
      int lo = $urandom_range(0, 14);
      int hi = $urandom_range(lo + 1, 15);
      int n = $urandom_range(0, 3);
      int sa = n == 0 ? $urandom_range(0, 40) :
               ($urandom_range(0, 1) ? -1 : $urandom_range(0, n * (hi - lo)));
      if ($urandom_range(0, 5) == 0) bad_cmd(hi, $urandom_range(0, hi));
      run_sweep(lo, hi, n, sa, 1'($urandom_range(0, 1)));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
